// File: rtl/mmio_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_pkg: register offsets and seven-segment glyph decode                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mmio_io_pkg;

   localparam int SEG_W         = 7;

   localparam int OFF_LED       = 0;
   localparam int OFF_SW        = 1;
   localparam int OFF_KEY_LEVEL = 2;
   localparam int OFF_KEY_EDGE  = 3;
   localparam int OFF_IRQ_EN    = 4;
   localparam int OFF_HEX_MODE  = 5;
   localparam int OFF_HEX_DATA  = 6;

   // Active-high segments, bit0 = a ... bit6 = g; b and d are lowercase glyphs.
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
      logic [SEG_W-1:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce: two-flop synchroniser plus stability counter for one key      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_debounce
   import mmio_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample that matches the accepted level restarts the stability window.
   always_comb begin
      meta_d  = key_raw;
      sync_d  = meta_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == TERM) begin
         level_d = sync_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_ctrl: memory-mapped LED/switch/key/seven-segment controller         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mmio_io_ctrl
   import mmio_io_pkg::*;
#(
   parameter int NUM_HEX         = 6,
   parameter int NUM_LED         = 10,
   parameter int NUM_SW          = 10,
   parameter int NUM_KEY         = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ADDR_W          = 4
) (
   input  logic                     Clock,
   input  logic                     Resetn,
   input  logic                     ReadData,
   input  logic                     WriteData,
   input  logic [ADDR_W-1:0]        Addr,
   input  logic [15:0]              WrData,
   output logic [15:0]              RdData,
   output logic                     DataDone,
   output logic [NUM_HEX*SEG_W-1:0] HEX,
   output logic [NUM_LED-1:0]       LEDR,
   input  logic [NUM_SW-1:0]        SW,
   input  logic [NUM_KEY-1:0]       KEY,
   output logic                     Irq
);

   logic [31:0]        addr_ext;
   logic [15:0]        rd_val;
   logic [NUM_KEY-1:0] key_level;
   logic [NUM_KEY-1:0] key_rise;
   logic [NUM_KEY-1:0] w1c;

   logic [NUM_LED-1:0] led_q, led_d;
   logic [NUM_KEY-1:0] irq_en_q, irq_en_d;
   logic [NUM_HEX-1:0] hex_mode_q, hex_mode_d;
   logic [SEG_W-1:0]   hex_data_q [NUM_HEX];
   logic [SEG_W-1:0]   hex_data_d [NUM_HEX];
   logic [NUM_KEY-1:0] key_edge_q, key_edge_d;
   logic [NUM_KEY-1:0] key_prev_q, key_prev_d;
   logic [NUM_SW-1:0]  sw_meta_q, sw_meta_d;
   logic [NUM_SW-1:0]  sw_sync_q, sw_sync_d;
   logic [15:0]        rd_data_q, rd_data_d;
   logic               done_q, done_d;

   assign addr_ext = 32'(Addr);

   generate
      for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_key_debounce (
            .clk    (Clock),
            .rst_n  (Resetn),
            .key_raw(KEY[k]),
            .level  (key_level[k])
         );
      end
   endgenerate

   assign key_rise = key_level & ~key_prev_q;

   // Read mux works on current register state, so a combined read+write returns the pre-write value.
   always_comb begin
      rd_val = '0;
      case (addr_ext)
         OFF_LED:       rd_val[NUM_LED-1:0] = led_q;
         OFF_SW:        rd_val[NUM_SW-1:0]  = sw_sync_q;
         OFF_KEY_LEVEL: rd_val[NUM_KEY-1:0] = key_level;
         OFF_KEY_EDGE:  rd_val[NUM_KEY-1:0] = key_edge_q;
         OFF_IRQ_EN:    rd_val[NUM_KEY-1:0] = irq_en_q;
         OFF_HEX_MODE:  rd_val[NUM_HEX-1:0] = hex_mode_q;
         default: begin
            for (int i = 0; i < NUM_HEX; i++) begin
               if (addr_ext == 32'(OFF_HEX_DATA + i)) begin
                  rd_val[SEG_W-1:0] = hex_data_q[i];
               end
            end
         end
      endcase
   end

   always_comb begin
      led_d      = led_q;
      irq_en_d   = irq_en_q;
      hex_mode_d = hex_mode_q;
      hex_data_d = hex_data_q;
      w1c        = '0;
      key_prev_d = key_level;
      sw_meta_d  = SW;
      sw_sync_d  = sw_meta_q;
      rd_data_d  = ReadData ? rd_val : rd_data_q;
      done_d     = ReadData | WriteData;
      if (WriteData) begin
         case (addr_ext)
            OFF_LED:      led_d      = WrData[NUM_LED-1:0];
            OFF_KEY_EDGE: w1c        = WrData[NUM_KEY-1:0];
            OFF_IRQ_EN:   irq_en_d   = WrData[NUM_KEY-1:0];
            OFF_HEX_MODE: hex_mode_d = WrData[NUM_HEX-1:0];
            default: begin
               for (int i = 0; i < NUM_HEX; i++) begin
                  if (addr_ext == 32'(OFF_HEX_DATA + i)) begin
                     hex_data_d[i] = WrData[SEG_W-1:0];
                  end
               end
            end
         endcase
      end
      // A fresh edge beats a simultaneous clear of the same bit.
      key_edge_d = (key_edge_q & ~w1c) | key_rise;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         led_q      <= '0;
         irq_en_q   <= '0;
         hex_mode_q <= '0;
         for (int i = 0; i < NUM_HEX; i++) begin
            hex_data_q[i] <= '0;
         end
         key_edge_q <= '0;
         key_prev_q <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         led_q      <= led_d;
         irq_en_q   <= irq_en_d;
         hex_mode_q <= hex_mode_d;
         for (int i = 0; i < NUM_HEX; i++) begin
            hex_data_q[i] <= hex_data_d[i];
         end
         key_edge_q <= key_edge_d;
         key_prev_q <= key_prev_d;
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
         assign HEX[i*SEG_W +: SEG_W] = hex_mode_q[i] ? hex_to_seg(hex_data_q[i][3:0])
                                                      : hex_data_q[i];
      end
   endgenerate

   assign LEDR     = led_q;
   assign RdData   = rd_data_q;
   assign DataDone = done_q;
   assign Irq      = |(key_edge_q & irq_en_q);

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmio_io_ctrl: scoreboard bench with a register-level reference model     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mmio_io_ctrl;

   localparam int NH = 6;
   localparam int NL = 10;
   localparam int NS = 10;
   localparam int NK = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          Resetn;
   logic          rd, wr;
   logic [3:0]    addr;
   logic [15:0]   wdata;
   logic [15:0]   RdData;
   logic          DataDone;
   logic [NH*7-1:0] HEX;
   logic [NL-1:0] LEDR;
   logic [NS-1:0] SW;
   logic [NK-1:0] KEY;
   logic          Irq;

   int total = 0;
   int bad   = 0;

   mmio_io_ctrl #(
      .NUM_HEX(NH), .NUM_LED(NL), .NUM_SW(NS), .NUM_KEY(NK),
      .DEBOUNCE_CYCLES(DC), .ADDR_W(4)
   ) dut (
      .Clock(clk), .Resetn(Resetn), .ReadData(rd), .WriteData(wr),
      .Addr(addr), .WrData(wdata), .RdData(RdData), .DataDone(DataDone),
      .HEX(HEX), .LEDR(LEDR), .SW(SW), .KEY(KEY), .Irq(Irq)
   );

   always #5 clk = ~clk;

   // Reference model: architectural register contents plus key/switch timing rules.
   logic [NL-1:0] m_led;
   logic [NK-1:0] m_irq_en;
   logic [NH-1:0] m_mode;
   logic [6:0]    m_hex [NH];
   logic [NK-1:0] m_edge, m_level, m_rise;
   int            m_run [NK];
   logic [NK-1:0] kh1, kh2;
   logic [NS-1:0] sh1, sh2;
   logic [15:0]   last_rd;
   logic [15:0]   exp_q [$];
   logic [6:0]    glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = '0; m_irq_en = '0; m_mode = '0; m_edge = '0; m_level = '0; m_rise = '0;
      kh1 = '0; kh2 = '0; sh1 = '0; sh2 = '0; last_rd = '0;
      for (int i = 0; i < NH; i++) m_hex[i] = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      exp_q.delete();
   endtask

   function automatic logic [15:0] model_read(input int a);
      logic [15:0] v;
      v = '0;
      if (a == 0)      v[NL-1:0] = m_led;
      else if (a == 1) v[NS-1:0] = sh2;
      else if (a == 2) v[NK-1:0] = m_level;
      else if (a == 3) v[NK-1:0] = m_edge;
      else if (a == 4) v[NK-1:0] = m_irq_en;
      else if (a == 5) v[NH-1:0] = m_mode;
      else if (a >= 6 && a < 6 + NH) v[6:0] = m_hex[a-6];
      return v;
   endfunction

   function automatic logic [NH*7-1:0] model_hex();
      logic [NH*7-1:0] h;
      for (int i = 0; i < NH; i++)
         h[i*7 +: 7] = m_mode[i] ? glyph[m_hex[i][3:0]] : m_hex[i];
      return h;
   endfunction

   // Effect of one clock edge on the model, using the inputs sampled at that edge.
   task automatic model_edge(input bit w, input int a, input logic [15:0] d);
      logic [NK-1:0] w1c, rise_next;
      w1c = (w && a == 3) ? d[NK-1:0] : '0;
      m_edge = (m_edge & ~w1c) | m_rise;
      if (w) begin
         if (a == 0) m_led = d[NL-1:0];
         else if (a == 4) m_irq_en = d[NK-1:0];
         else if (a == 5) m_mode = d[NH-1:0];
         else if (a >= 6 && a < 6 + NH) m_hex[a-6] = d[6:0];
      end
      rise_next = '0;
      // A key level flips once its synchronised input has disagreed for DC consecutive edges.
      for (int k = 0; k < NK; k++) begin
         if (kh2[k] == m_level[k]) m_run[k] = 0;
         else begin
            m_run[k]++;
            if (m_run[k] == DC) begin
               m_level[k] = kh2[k];
               m_run[k] = 0;
               rise_next[k] = kh2[k];
            end
         end
      end
      m_rise = rise_next;
      kh2 = kh1; kh1 = KEY;
      sh2 = sh1; sh1 = SW;
   endtask

   task automatic step(input bit r, input bit w, input int a, input logic [15:0] d);
      logic [15:0] e;
      rd = r; wr = w; addr = 4'(a); wdata = d;
      e = r ? model_read(a) : last_rd;
      @(posedge clk);
      if (r || w) exp_q.push_back(e);
      if (r) last_rd = e;
      model_edge(w, a, d);
      #1;
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
   endtask

   always @(negedge clk) begin
      if (DataDone) begin
         if (exp_q.size() == 0) chk("spurious_done", 64'(DataDone), 64'd0);
         else chk("rddata", 64'(RdData), 64'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
         chk("missing_done", 64'(DataDone), 64'd1);
         exp_q.delete();
      end
      chk("ledr", 64'(LEDR), 64'(m_led));
      chk("irq", 64'(Irq), 64'(|(m_edge & m_irq_en)));
      chk("hex", 64'(HEX), 64'(model_hex()));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Resetn = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0; SW = '0; KEY = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 Resetn = 1'b1;

      step(1, 0, 0, 16'h0);
      step(1, 0, 1, 16'h0);
      step(0, 1, 0, 16'h03FF);
      step(1, 0, 0, 16'h0);
      step(0, 1, 15, 16'hFFFF);
      step(1, 0, 15, 16'h0);
      idle(2);

      step(0, 1, 5, 16'h0001);
      step(0, 1, 6, 16'h000A);
      step(0, 1, 5, 16'h0000);
      step(0, 1, 7, 16'h0049);
      step(1, 1, 7, 16'h0012);
      step(1, 0, 7, 16'h0);

      KEY = 4'b0100;
      idle(8);
      step(1, 0, 2, 16'h0);
      step(1, 0, 3, 16'h0);
      step(0, 1, 4, 16'h0004);
      idle(2);
      step(0, 1, 3, 16'h0004);
      step(1, 0, 3, 16'h0);
      KEY = 4'b0000;
      idle(8);
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) KEY[0] = ~KEY[0];
         step(0, 0, 0, 16'h0);
      end
      KEY = 4'b0000;
      idle(8);
      step(1, 0, 2, 16'h0);

      step(0, 1, 3, 16'h000F);
      KEY[1] = 1'b1;
      n = 0;
      while (!m_rise[1] && n < 20) begin
         step(0, 0, 0, 16'h0);
         n++;
      end
      chk("edge_wait", 64'(n < 20), 64'd1);
      step(0, 1, 3, 16'h0002);
      step(1, 0, 3, 16'h0);
      KEY = '0;
      idle(8);

      step(0, 1, 0, 16'h0155);
      rd = 0; wr = 1; addr = 4; wdata = 16'h000F;
      #2 Resetn = 1'b0;
      model_reset();
      @(posedge clk);
      #1 wr = 0;
      @(posedge clk);
      #1 Resetn = 1'b1;
      step(1, 0, 4, 16'h0);
      step(1, 0, 0, 16'h0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) KEY = NK'($urandom);
         if ($urandom_range(5) == 0) SW = NS'($urandom);
         step(bit'($urandom_range(1)), bit'($urandom_range(1)),
              int'($urandom_range(15)), 16'($urandom));
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
